// File: rtl/sw_input_pkg.sv
// Shared definitions for the switch input-conditioning stage that feeds the
// 4-to-2 decoder.
package sw_input_pkg;

  localparam int NUM_SW                = 4;
  localparam int DEFAULT_STABLE_CYCLES = 500000;
  localparam int DEFAULT_SYNC_STAGES   = 2;

  typedef logic [NUM_SW-1:0] sw_code_t;

  // Counter must be able to hold STABLE_CYCLES-1 at its widest.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: flop-chain synchronizer, stability counter and committed
// value. commit is high in the cycle whose rising edge accepts a new value.
module debounce_bit
  import sw_input_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic commit
);

  localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync;
  logic                   stable_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   mismatch;

  // Plain shift chain, nothing between stages, so metastability settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync     = sync_reg[SYNC_STAGES-1];
  assign mismatch = sync ^ stable_reg;
  assign commit   = mismatch && (cnt_reg == CNT_LAST);

  // Any agreement with the committed value restarts the count from zero.
  always_comb begin
    cnt_next = '0;
    if (mismatch && !commit) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (commit) begin
        stable_reg <= sync;
      end
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/switch_debounce_4b.sv
// Four independently debounced switches presented as a registered code plus a
// single-cycle strobe marking the edge on which the code changed.
module switch_debounce_4b
  import sw_input_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_raw,
  output logic [3:0] code,
  output logic       code_changed
);

  sw_code_t stable_bits;
  sw_code_t commit_bits;
  logic     code_changed_reg;

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_bit
      debounce_bit #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES)
      ) u_debounce_bit (
        .clk   (clk),
        .rst   (rst),
        .raw   (sw_raw[gi]),
        .stable(stable_bits[gi]),
        .commit(commit_bits[gi])
      );
    end
  endgenerate

  // Registered on the same edge the committed bits update, so the strobe and
  // the new code appear together; simultaneous commits give one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_changed_reg <= 1'b0;
    end else begin
      code_changed_reg <= |commit_bits;
    end
  end

  assign code         = stable_bits;
  assign code_changed = code_changed_reg;

endmodule

// File: tb/tb_switch_debounce_4b.sv
// Scoreboard bench for switch_debounce_4b with STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_switch_debounce_4b;

  localparam int SC = 4;
  localparam int SS = 2;
  localparam int HL = SC + SS;

  typedef struct packed {
    logic [3:0] code;
    logic       chg;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] sw_raw;
  logic [3:0] code;
  logic       code_changed;

  switch_debounce_4b #(
    .STABLE_CYCLES(SC),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .code        (code),
    .code_changed(code_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb_q[$];

  // Reference: raw-sample history per bit; a bit flips when the last SC
  // synchronized samples all disagree with the expected committed value.
  logic [HL-1:0] hist_m [4];
  logic [3:0]    s_m = 4'b0000;

  int cyc            = 0;
  int pulse_cnt      = 0;
  int last_pulse_cyc = 0;
  int prev_pulse_cyc = 0;
  int dec_toggles    = 0;
  logic [1:0] dec_prev = 2'b00;
  logic [1:0] dec_y;
  exp_t       mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Downstream 4-to-2 encoder: A=I0, B=I1, C=I2, D=I3, highest index wins.
  function automatic logic [1:0] enc(input logic [3:0] c);
    if (c[0])      return 2'd3;
    else if (c[1]) return 2'd2;
    else if (c[2]) return 2'd1;
    else           return 2'd0;
  endfunction

  task automatic push_expect(input logic [3:0] raw, input logic r);
    logic [3:0] commit;
    logic       all_diff;
    commit = 4'b0000;
    if (r) begin
      s_m = 4'b0000;
      for (int b = 0; b < 4; b++) hist_m[b] = '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int j = SS - 1; j < SS - 1 + SC; j++) begin
          if (hist_m[b][j] == s_m[b]) all_diff = 1'b0;
        end
        commit[b] = all_diff;
        hist_m[b] = {hist_m[b][HL-2:0], raw[b]};
      end
      s_m = s_m ^ commit;
    end
    sb_q.push_back('{code: s_m, chg: |commit});
  endtask

  // Drive one cycle of stimulus, record its expectation, and let the edge pass.
  task automatic step(input logic [3:0] raw, input logic r);
    sw_raw = raw;
    rst    = r;
    push_expect(raw, r);
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  task automatic wait_code(input logic [3:0] raw, input logic [3:0] target, output int n);
    n = 0;
    do begin
      step(raw, 1'b0);
      n++;
    end while (code !== target && n < 20);
  endtask

  // Monitor: compare DUT against the scoreboard just after each edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    dec_y = enc(code);
    if (dec_y !== dec_prev) dec_toggles++;
    dec_prev = dec_y;
    if (code_changed === 1'b1) begin
      pulse_cnt++;
      prev_pulse_cyc = last_pulse_cyc;
      last_pulse_cyc = cyc;
    end
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("code", 32'(code), 32'(mon_e.code));
      check("code_changed", 32'(code_changed), 32'(mon_e.chg));
      $display("cyc %0d raw=%b rst=%b code=%b chg=%b exp_code=%b exp_chg=%b",
               cyc, sw_raw, rst, code, code_changed, mon_e.code, mon_e.chg);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int p0;
    int t0;
    logic [1:0] y;

    for (int b = 0; b < 4; b++) hist_m[b] = '0;
    rst    = 1'b1;
    sw_raw = 4'b0000;
    @(posedge clk);
    #2;

    // Reset held with all switches on, then release.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
    check("rst_code", 32'(code), 32'h0);
    check("rst_chg", 32'(code_changed), 32'h0);
    p0 = pulse_cnt;
    wait_code(4'b1111, 4'b1111, n);
    check("rst_latency", 32'(n), 32'd6);
    steps(4'b1111, 2);
    check("rst_pulses", 32'(pulse_cnt - p0), 32'd1);
    steps(4'b0000, 8);

    // Glitch of 3 cycles on bit 0.
    p0 = pulse_cnt;
    steps(4'b0001, 3);
    steps(4'b0000, 8);
    check("glitch_code", 32'(code), 32'h0);
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Exactly-threshold pulse on bit 2.
    p0 = pulse_cnt;
    steps(4'b0100, 4);
    steps(4'b0000, 2);
    check("thr_rise", 32'(code), 32'h4);
    steps(4'b0000, 8);
    check("thr_fall", 32'(code), 32'h0);
    check("thr_pulses", 32'(pulse_cnt - p0), 32'd2);

    // Simultaneous commit of two bits.
    p0 = pulse_cnt;
    steps(4'b1010, 8);
    check("simul_code", 32'(code), 32'ha);
    check("simul_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Staggered commits two cycles apart.
    p0 = pulse_cnt;
    steps(4'b1011, 2);
    steps(4'b1111, 8);
    check("stag_code", 32'(code), 32'hf);
    check("stag_pulses", 32'(pulse_cnt - p0), 32'd2);
    check("stag_gap", 32'(last_pulse_cyc - prev_pulse_cyc), 32'd2);
    steps(4'b0000, 8);

    // Reset asserted on the 4th edge of a pending change.
    p0 = pulse_cnt;
    steps(4'b0001, 3);
    step(4'b0001, 1'b1);
    check("midrst_code", 32'(code), 32'h0);
    wait_code(4'b0001, 4'b0001, n);
    check("midrst_latency", 32'(n), 32'd6);
    check("midrst_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Bounce back to the committed value mid-count.
    p0 = pulse_cnt;
    steps(4'b0000, 3);
    steps(4'b0001, 1);
    steps(4'b0000, 3);
    steps(4'b0001, 6);
    check("bounce_code", 32'(code), 32'h1);
    check("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Integration with the downstream encoder.
    steps(4'b0100, 8);
    y = enc(code);
    check("dec_y0", 32'(y[0]), 32'd1);
    check("dec_y1", 32'(y[1]), 32'd0);
    t0 = dec_toggles;
    for (int i = 0; i < 6; i++) begin
      steps(4'b0000, 2);
      steps(4'b0100, 2);
    end
    check("dec_toggles", 32'(dec_toggles - t0), 32'd0);
    check("dec_code", 32'(code), 32'h4);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce_4b.md
Name: switch_debounce_4b

Overview:
- Input-conditioning stage placed directly upstream of the 4-to-2 decoder. It takes the four raw board switches and produces the clean A, B, C and D inputs that the decoder combines.
- Each raw switch is synchronized into the clock domain and debounced with its own stability counter.
- The block presents a registered, glitch-free 4-bit code plus a one-cycle change strobe. The decoder and its 7-segment display therefore see only settled values.

Parameters:
- STABLE_CYCLES, 500000, number of consecutive clock cycles a synchronized input must differ from the committed value before it is accepted. 500000 is 10 ms at 50 MHz. Legal range is 1 or more.
- SYNC_STAGES, 2, depth of the flip-flop synchronizer chain for each bit. Legal range is 2 or more.

Ports:
- clk    input   1  system clock (single clock domain)
- rst    input   1  synchronous, active-high reset
- sw_raw input   4  asynchronous raw switches; [3]=A, [2]=B, [1]=C, [0]=D
- code   output  4  debounced committed value, same bit mapping as sw_raw; drives decoder A,B,C,D
- code_changed output 1  one-cycle pulse, high in the cycle in which code first shows a new value

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset is sampled only on the rising edge of clk.
  - While rst is high at an edge, all of the following clear to 0: synchronizer flops, committed state, counters, code, and code_changed.
- Reset values: code=4'b0000, code_changed=0.
- Synchronizer:
  - sw_raw[i] passes through SYNC_STAGES flops. The last stage is sync[i].
  - No logic is placed between the stages.
- Per-bit debounce (bit i, independent for each bit):
  - Each bit holds a committed value s[i] and a counter cnt[i] of width $clog2(STABLE_CYCLES+1).
  - If sync[i]==s[i], then cnt[i]<=0. This covers any glitch shorter than the threshold.
  - If sync[i]!=s[i] and cnt[i]<STABLE_CYCLES-1, then cnt[i]<=cnt[i]+1.
  - If sync[i]!=s[i] and cnt[i]==STABLE_CYCLES-1, then s[i]<=sync[i] and cnt[i]<=0. This is the commit.
  - The counter never wraps and never exceeds STABLE_CYCLES-1.
- Outputs:
  - code is s[3:0] driven directly from the registers, with no combinational path from sw_raw.
  - code_changed is registered at the same edge as the commit. It is high for exactly one cycle.
- Latency:
  - A raw change that stays stable updates code after exactly SYNC_STAGES+STABLE_CYCLES rising edges. The count includes the edge that first samples the new raw value.
  - With the defaults (2 + 500000) this is about 10 ms.
- Boundary conditions:
  - Short pulses: a raw pulse shorter than STABLE_CYCLES cycles at sync[i] produces no change to code and no strobe.
  - Exact threshold: a pulse lasting exactly STABLE_CYCLES cycles at sync[i] commits.
  - Simultaneous commits: when several bits commit on the same edge, code updates all of them together and code_changed pulses once.
  - Staggered commits: each commit edge produces its own pulse, even on back-to-back cycles.
  - Bounce back to committed value: a raw input returning to the committed value mid-count clears that bit's counter. Counting restarts from 0 on the next mismatch.
  - Reset mid-count: the count is discarded and code returns to 0. After release, a full SYNC_STAGES+STABLE_CYCLES edges are needed before code can change.
  - STABLE_CYCLES=1: a bit commits on the first edge at which sync[i] differs from s[i].

Decomposition:
- Shared package sw_input_pkg:
  - NUM_SW=4
  - DEFAULT_STABLE_CYCLES=500000
  - DEFAULT_SYNC_STAGES=2
  - typedef logic [NUM_SW-1:0] sw_code_t, used for sw_raw and code
- Sub-module debounce_bit:
  - Contains one bit's synchronizer, counter and committed flop.
  - Parameters: STABLE_CYCLES, SYNC_STAGES.
  - Ports: clk, rst, raw, stable, commit.
  - The top instantiates four debounce_bit instances.
  - code_changed is the registered OR of the four commit signals, aligned with stable.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2):
- Reset: hold rst=1 for 3 cycles with sw_raw=4'b1111, then release. During reset, code=0000 and code_changed=0. code becomes 1111 on the 6th edge after release, with a single code_changed pulse on that edge.
- Glitch rejection: code=0000; set sw_raw[0]=1 for 3 cycles, then 0. code stays 0000 and code_changed is never asserted.
- Threshold: set sw_raw[2]=1 for exactly 4 cycles, then 0. code goes to 0100 six edges after the rise, with one pulse. Six edges after the fall, code returns to 0000 with a second pulse.
- Simultaneous and staggered commits:
  - Set sw_raw=4'b1010 in one cycle. code goes to 1010 on a single edge with one pulse.
  - Then set bit 0 and, 2 cycles later, bit 2. This gives 1011 then 1111, with two pulses 2 cycles apart.
- Reset mid-count: set sw_raw=4'b0001, then assert rst for 1 cycle on the 4th edge. code stays 0000 throughout. After release, code goes to 0001 exactly 6 edges later.
- Integration: drive code into the decoder with sw_raw=4'b0100 (A=0, B=1, C=0, D=0). After debounce, Y0=1 and Y1=0. No intermediate decoder output toggles appear while sw_raw bounces 0100↔0000 every 2 cycles.
